// File: rtl/gb_lengthbank.sv
// Multi-channel APU length-counter bank: one down-counter per channel gates that
// channel's output after a programmed number of frame-sequencer length ticks.
module gb_lengthbank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_length_ctr,
    input  logic                        seq_first_half,
    input  logic [NUM_CH-1:0]           start,
    input  logic [NUM_CH-1:0]           single,
    input  logic [NUM_CH-1:0]           load,
    input  logic [NUM_CH*WIDTH-1:0]     load_value,
    input  logic [NUM_CH-1:0]           dac_off,
    output logic [NUM_CH-1:0]           enable,
    output logic [NUM_CH*(WIDTH+1)-1:0] remaining
);

    // The extra bit lets the counter hold 2**WIDTH exactly.
    localparam logic [WIDTH:0] FullCount = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] OneCount  = {{WIDTH{1'b0}}, 1'b1};

    logic [NUM_CH-1:0][WIDTH:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]          en_q, en_d;
    logic [NUM_CH-1:0]          single_q;

    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clk_length_ctr && single[i] && (cnt_d[i] != '0)) begin
                cnt_d[i] = cnt_d[i] - OneCount;
                if (cnt_d[i] == '0) begin
                    en_d[i] = 1'b0;
                end
            end

            // Enabling length during the first half of a sequencer period clocks it once.
            if (single[i] && !single_q[i] && seq_first_half && !clk_length_ctr &&
                (cnt_d[i] != '0)) begin
                cnt_d[i] = cnt_d[i] - OneCount;
                if ((cnt_d[i] == '0) && !start[i]) begin
                    en_d[i] = 1'b0;
                end
            end

            if (load[i]) begin
                cnt_d[i] = FullCount - {1'b0, load_value[i*WIDTH +: WIDTH]};
            end

            if (start[i]) begin
                en_d[i] = 1'b1;
                if (cnt_d[i] == '0) begin
                    cnt_d[i] = (single[i] && seq_first_half) ? FullCount - OneCount : FullCount;
                end
            end

            if (dac_off[i]) begin
                en_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            en_q     <= '0;
            single_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            single_q <= single;
        end
    end

    assign enable    = en_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_gb_lengthbank.sv
// Self-checking bench for gb_lengthbank: directed scenarios plus randomized traffic
// compared against an integer rule model of the length counters.
module tb_gb_lengthbank;

    localparam int NCH = 4;
    localparam int W   = 6;
    localparam int MAXLEN = 64;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   clk_length_ctr = 1'b0;
    logic                   seq_first_half = 1'b0;
    logic [NCH-1:0]         start = '0;
    logic [NCH-1:0]         single = '0;
    logic [NCH-1:0]         load = '0;
    logic [NCH*W-1:0]       load_value = '0;
    logic [NCH-1:0]         dac_off = '0;
    logic [NCH-1:0]         enable;
    logic [NCH*(W+1)-1:0]   remaining;

    int total = 0;
    int bad = 0;

    int m_cnt [NCH];
    int m_en  [NCH];
    int m_sq  [NCH];

    gb_lengthbank #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_length_ctr (clk_length_ctr),
        .seq_first_half (seq_first_half),
        .start          (start),
        .single         (single),
        .load           (load),
        .load_value     (load_value),
        .dac_off        (dac_off),
        .enable         (enable),
        .remaining      (remaining)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_en[i]  = 0;
            m_sq[i]  = 0;
        end
    endtask

    // Applies the per-cycle rules in order using plain integers.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            int c, e, lv;
            c  = m_cnt[i];
            e  = m_en[i];
            lv = int'(load_value[i*W +: W]);
            if (clk_length_ctr && single[i] && c > 0) begin
                c = c - 1;
                if (c == 0) e = 0;
            end
            if (single[i] && m_sq[i] == 0 && seq_first_half && !clk_length_ctr && c > 0) begin
                c = c - 1;
                if (c == 0 && !start[i]) e = 0;
            end
            if (load[i]) c = MAXLEN - lv;
            if (start[i]) begin
                e = 1;
                if (c == 0) c = (single[i] && seq_first_half) ? MAXLEN - 1 : MAXLEN;
            end
            if (dac_off[i]) e = 0;
            m_cnt[i] = c;
            m_en[i]  = e;
            m_sq[i]  = int'(single[i]);
        end
    endtask

    function automatic logic [NCH-1:0] exp_en();
        for (int i = 0; i < NCH; i++) exp_en[i] = (m_en[i] != 0);
    endfunction

    function automatic logic [NCH*(W+1)-1:0] exp_rem();
        for (int i = 0; i < NCH; i++) exp_rem[i*(W+1) +: W+1] = 7'(m_cnt[i]);
    endfunction

    function automatic int rem_of(input int ch);
        return int'(remaining[ch*(W+1) +: W+1]);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        start = '0;
        load = '0;
        clk_length_ctr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        single = '0; dac_off = '0; seq_first_half = 1'b0;
        do_reset();
        total++;
        if (enable !== '0) begin
            bad++; $display("FAIL reset_enable: got %b want 0", enable);
        end
        total++;
        if (remaining !== '0) begin
            bad++; $display("FAIL reset_remaining: got %h want 0", remaining);
        end
    endtask

    task automatic test_tick_countdown();
        load_value[0 +: W] = 6'd60; load[0] = 1'b1;
        step();
        start[0] = 1'b1; single[0] = 1'b1;
        step();
        total++;
        if (enable[0] !== 1'b1 || rem_of(0) != 4) begin
            bad++; $display("FAIL tick_start: got en=%b rem=%0d want en=1 rem=4", enable[0], rem_of(0));
        end
        for (int k = 0; k < 6; k++) begin
            int want_rem;
            logic want_en;
            want_rem = (k < 4) ? 3 - k : 0;
            want_en  = (k < 3);
            clk_length_ctr = 1'b1;
            step();
            total++;
            if (enable[0] !== want_en || rem_of(0) != want_rem) begin
                bad++;
                $display("FAIL tick_%0d: got en=%b rem=%0d want en=%b rem=%0d",
                         k, enable[0], rem_of(0), want_en, want_rem);
            end
        end
        total++;
        if (enable !== exp_en() || remaining !== exp_rem()) begin
            bad++; $display("FAIL tick_model: got %b/%h want %b/%h", enable, remaining, exp_en(), exp_rem());
        end
    endtask

    task automatic test_start_reload();
        single[0] = 1'b0; start[0] = 1'b1;
        step();
        total++;
        if (enable[0] !== 1'b1 || rem_of(0) != 64) begin
            bad++; $display("FAIL reload_64: got en=%b rem=%0d want en=1 rem=64", enable[0], rem_of(0));
        end
        for (int k = 0; k < 64; k++) begin
            clk_length_ctr = 1'b1;
            step();
        end
        total++;
        if (enable[0] !== 1'b1 || rem_of(0) != 64) begin
            bad++; $display("FAIL hold_single0: got en=%b rem=%0d want en=1 rem=64", enable[0], rem_of(0));
        end
    endtask

    task automatic test_reload_first_half();
        single = '0;
        do_reset();
        single[1] = 1'b1; seq_first_half = 1'b1; start[1] = 1'b1;
        step();
        total++;
        if (enable[1] !== 1'b1 || rem_of(1) != 63) begin
            bad++; $display("FAIL reload_63: got en=%b rem=%0d want en=1 rem=63", enable[1], rem_of(1));
        end
        seq_first_half = 1'b0; single[2] = 1'b1; start[2] = 1'b1;
        step();
        total++;
        if (enable[2] !== 1'b1 || rem_of(2) != 64) begin
            bad++; $display("FAIL reload_sfh0: got en=%b rem=%0d want en=1 rem=64", enable[2], rem_of(2));
        end
    endtask

    task automatic test_extra_clock();
        single[3] = 1'b0; seq_first_half = 1'b0;
        load_value[3*W +: W] = 6'd63; load[3] = 1'b1; start[3] = 1'b1;
        step();
        total++;
        if (enable[3] !== 1'b1 || rem_of(3) != 1) begin
            bad++; $display("FAIL extra_setup: got en=%b rem=%0d want en=1 rem=1", enable[3], rem_of(3));
        end
        single[3] = 1'b1; seq_first_half = 1'b1;
        step();
        total++;
        if (enable[3] !== 1'b0 || rem_of(3) != 0) begin
            bad++; $display("FAIL extra_kill: got en=%b rem=%0d want en=0 rem=0", enable[3], rem_of(3));
        end
        single[3] = 1'b0; seq_first_half = 1'b0; load[3] = 1'b1;
        step();
        single[3] = 1'b1; seq_first_half = 1'b1; start[3] = 1'b1;
        step();
        total++;
        if (enable[3] !== 1'b1 || rem_of(3) != 63) begin
            bad++; $display("FAIL extra_start: got en=%b rem=%0d want en=1 rem=63", enable[3], rem_of(3));
        end
        seq_first_half = 1'b0;
    endtask

    task automatic test_load_tick();
        single = '0;
        do_reset();
        for (int i = 0; i < NCH; i++) load_value[i*W +: W] = 6'(40 + i);
        load = '1; start = '1;
        step();
        single = '1;
        step();
        load_value[2*W +: W] = 6'd10; load[2] = 1'b1; clk_length_ctr = 1'b1;
        step();
        total++;
        if (rem_of(2) != 54 || rem_of(0) != 23 || rem_of(1) != 22 || rem_of(3) != 20) begin
            bad++;
            $display("FAIL load_tick: got %0d %0d %0d %0d want 23 22 54 20",
                     rem_of(0), rem_of(1), rem_of(2), rem_of(3));
        end
        total++;
        if (enable !== exp_en() || remaining !== exp_rem()) begin
            bad++; $display("FAIL load_tick_model: got %b/%h want %b/%h", enable, remaining, exp_en(), exp_rem());
        end
    endtask

    task automatic test_dac_and_reset();
        dac_off[0] = 1'b1; start = '1;
        step();
        total++;
        if (enable !== 4'b1110) begin
            bad++; $display("FAIL dac_start: got %b want 1110", enable);
        end
        dac_off = '0;
        clk_length_ctr = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (enable !== '0 || remaining !== '0) begin
            bad++; $display("FAIL async_reset: got %b/%h want 0/0", enable, remaining);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        single = '0; start[1] = 1'b1;
        step();
        total++;
        if (enable !== 4'b0010 || rem_of(1) != 64) begin
            bad++; $display("FAIL post_reset_start: got en=%b rem=%0d want en=0010 rem=64", enable, rem_of(1));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) load_value[i*W +: W] = 6'($urandom_range(40, 63));
            start = 4'($urandom & $urandom & $urandom);
            load = 4'($urandom & $urandom & $urandom);
            dac_off = 4'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) single = 4'($urandom);
            seq_first_half = 1'($urandom);
            clk_length_ctr = ($urandom_range(0, 2) == 0);
            step();
            total++;
            if (enable !== exp_en() || remaining !== exp_rem()) begin
                bad++;
                $display("FAIL random_%0d: got %b/%h want %b/%h", n, enable, remaining, exp_en(), exp_rem());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tick_countdown();
        test_start_reload();
        test_reload_first_half();
        test_extra_clock();
        test_load_tick();
        test_dac_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
